// File: rtl/io_dev_pkg.sv
// rtl/io_dev_pkg.sv - shared types and constants for the I/O device responder
package io_dev_pkg;

  // Bus handshake sequencer states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ACK  = 2'd2,
    REL  = 2'd3
  } state_t;

  // Register offsets within the 4-byte window (PA[1:0])
  localparam logic [1:0] OFS_DATA = 2'd0;
  localparam logic [1:0] OFS_CTRL = 2'd1;
  localparam logic [1:0] OFS_STAT = 2'd2;
  localparam logic [1:0] OFS_CNT  = 2'd3;

  // Wait-state counter width (0..15 wait states)
  localparam int CNT_W = 4;

endpackage

// File: rtl/io_sync2.sv
// rtl/io_sync2.sv - two-flop synchronizer for an asynchronous active-low strobe
module io_sync2 (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_q;

  // Resets to 1 so an active-low strobe reads as idle until it is really sampled
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_meta <= 1'b1;
      r_q    <= 1'b1;
    end else begin
      r_meta <= i_d;
      r_q    <= r_meta;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/io_dev_responder.sv
// rtl/io_dev_responder.sv - I/O device window responder with wait states and IRQ
module io_dev_responder #(
  parameter logic [7:0] BASE_ADDR   = 8'h40,
  parameter int         WAIT_CYCLES = 2
) (
  input  logic       sysclk,
  input  logic       sys_rst,
  input  logic       IORQ_n,
  input  logic       WRITE,
  input  logic [7:0] PA_7_0,
  input  logic [7:0] IDB_7_0_IN,
  output logic [7:0] IDB_7_0_OUT,
  output logic       IDB_OE,
  output logic       RDY_n,
  input  logic       EVENT,
  output logic [7:0] CTRL_OUT,
  output logic       IRQ_n
);

  import io_dev_pkg::*;

  localparam logic [CNT_W-1:0] W_INIT = CNT_W'(WAIT_CYCLES);

  logic             w_rq_s;
  logic             w_hit;
  logic [1:0]       r_settle;
  logic             r_armed;
  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_next;
  logic             w_ack_entry;
  logic             w_release;
  logic             w_disarm;
  logic             w_w1c;
  logic [7:0]       w_rd_mux;

  logic [7:0]       r_data;
  logic [7:0]       r_ctrl;
  logic             r_stat0;
  logic [7:0]       r_acccnt;
  logic [7:0]       r_dout;
  logic             r_oe;
  logic             r_rdy_n;
  logic             r_irq_n;

  io_sync2 u_sync_iorq (
    .i_clk (sysclk),
    .i_rst (sys_rst),
    .i_d   (IORQ_n),
    .o_q   (w_rq_s)
  );

  assign w_hit = (PA_7_0[7:2] == BASE_ADDR[7:2]);
  assign w_w1c = w_ack_entry & WRITE & (PA_7_0[1:0] == OFS_STAT) & IDB_7_0_IN[0];

  // Synchronizer flops come out of reset as 1; ignore rq_s until both have
  // sampled the real pin, so a request held low through reset never arms
  always_ff @(posedge sysclk or posedge sys_rst) begin
    if (sys_rst) r_settle <= 2'b00;
    else         r_settle <= {r_settle[0], 1'b1};
  end

  // Armed once the bus is seen idle; a miss disarms until the next idle
  always_ff @(posedge sysclk or posedge sys_rst) begin
    if (sys_rst)                     r_armed <= 1'b0;
    else if (w_rq_s && r_settle[1])  r_armed <= 1'b1;
    else if (w_disarm)               r_armed <= 1'b0;
  end

  // State and wait counter registers
  always_ff @(posedge sysclk or posedge sys_rst) begin
    if (sys_rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt_next;
    end
  end

  // Next state plus the one-cycle ACK entry / release strobes
  always_comb begin
    w_next      = r_state;
    w_cnt_next  = r_cnt;
    w_ack_entry = 1'b0;
    w_release   = 1'b0;
    w_disarm    = 1'b0;
    case (r_state)
      IDLE: begin
        if (!w_rq_s && r_armed) begin
          w_disarm = 1'b1;
          if (w_hit) begin
            if (WAIT_CYCLES == 0) begin
              w_next      = ACK;
              w_ack_entry = 1'b1;
            end else begin
              w_next     = WAIT;
              w_cnt_next = W_INIT;
            end
          end
        end
      end
      WAIT: begin
        if (w_rq_s) begin
          w_next = IDLE;
        end else if (r_cnt <= CNT_W'(1)) begin
          w_next      = ACK;
          w_ack_entry = 1'b1;
        end else begin
          w_cnt_next = r_cnt - CNT_W'(1);
        end
      end
      ACK: begin
        if (w_rq_s) begin
          w_next    = REL;
          w_release = 1'b1;
        end
      end
      REL:     w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Read data selection by register offset
  always_comb begin
    w_rd_mux = 8'h00;
    case (PA_7_0[1:0])
      OFS_DATA: w_rd_mux = r_data;
      OFS_CTRL: w_rd_mux = r_ctrl;
      OFS_STAT: w_rd_mux = {7'b0, r_stat0};
      default:  w_rd_mux = r_acccnt;
    endcase
  end

  // Bus-side outputs are set on ACK entry and cleared on release
  always_ff @(posedge sysclk or posedge sys_rst) begin
    if (sys_rst) begin
      r_rdy_n <= 1'b1;
      r_oe    <= 1'b0;
      r_dout  <= 8'h00;
    end else if (w_ack_entry) begin
      r_rdy_n <= 1'b0;
      if (!WRITE) begin
        r_oe   <= 1'b1;
        r_dout <= w_rd_mux;
      end
    end else if (w_release) begin
      r_rdy_n <= 1'b1;
      r_oe    <= 1'b0;
      r_dout  <= 8'h00;
    end
  end

  // Register file, access counter, sticky event flag and registered IRQ
  always_ff @(posedge sysclk or posedge sys_rst) begin
    if (sys_rst) begin
      r_data   <= 8'h00;
      r_ctrl   <= 8'h00;
      r_stat0  <= 1'b0;
      r_acccnt <= 8'h00;
      r_irq_n  <= 1'b1;
    end else begin
      r_irq_n <= ~(r_ctrl[0] & r_stat0);
      r_stat0 <= EVENT | (r_stat0 & ~w_w1c);
      if (w_ack_entry) begin
        r_acccnt <= r_acccnt + 8'd1;
        if (WRITE) begin
          case (PA_7_0[1:0])
            OFS_DATA: r_data <= IDB_7_0_IN;
            OFS_CTRL: r_ctrl <= IDB_7_0_IN;
            default:  ;
          endcase
        end
      end
    end
  end

  assign IDB_7_0_OUT = r_dout;
  assign IDB_OE      = r_oe;
  assign RDY_n       = r_rdy_n;
  assign CTRL_OUT    = r_ctrl;
  assign IRQ_n       = r_irq_n;

endmodule

// File: tb/tb_io_dev_responder.sv
// tb/tb_io_dev_responder.sv - self-checking bench for io_dev_responder
module tb_io_dev_responder;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       wr  = 1'b0;
  logic       ev  = 1'b0;
  logic [7:0] pa  = 8'h00;
  logic [7:0] din = 8'h00;
  logic [2:0] iorq_n = 3'b111;
  logic [2:0] rdy_n, oe, irq_n;
  logic [7:0] dout [3];
  logic [7:0] ctrl [3];

  int checks = 0;
  int errors = 0;
  int lat_tab [3] = '{5, 13, 3};
  logic [7:0] model_cnt [3] = '{8'h00, 8'h00, 8'h00};
  logic [7:0] sb_q [$];

  typedef struct {
    int         k;
    bit         w;
    logic [7:0] a;
    logic [7:0] d;
    bit         ack;
    logic [7:0] rd;
  } vec_t;
  vec_t tbl [15];

  always #5 clk = ~clk;

  io_dev_responder #(.BASE_ADDR(8'h40), .WAIT_CYCLES(2)) u0 (
    .sysclk(clk), .sys_rst(rst), .IORQ_n(iorq_n[0]), .WRITE(wr), .PA_7_0(pa),
    .IDB_7_0_IN(din), .IDB_7_0_OUT(dout[0]), .IDB_OE(oe[0]), .RDY_n(rdy_n[0]),
    .EVENT(ev), .CTRL_OUT(ctrl[0]), .IRQ_n(irq_n[0]));

  io_dev_responder #(.BASE_ADDR(8'h43), .WAIT_CYCLES(10)) u1 (
    .sysclk(clk), .sys_rst(rst), .IORQ_n(iorq_n[1]), .WRITE(wr), .PA_7_0(pa),
    .IDB_7_0_IN(din), .IDB_7_0_OUT(dout[1]), .IDB_OE(oe[1]), .RDY_n(rdy_n[1]),
    .EVENT(ev), .CTRL_OUT(ctrl[1]), .IRQ_n(irq_n[1]));

  io_dev_responder #(.BASE_ADDR(8'h40), .WAIT_CYCLES(0)) u2 (
    .sysclk(clk), .sys_rst(rst), .IORQ_n(iorq_n[2]), .WRITE(wr), .PA_7_0(pa),
    .IDB_7_0_IN(din), .IDB_7_0_OUT(dout[2]), .IDB_OE(oe[2]), .RDY_n(rdy_n[2]),
    .EVENT(ev), .CTRL_OUT(ctrl[2]), .IRQ_n(irq_n[2]));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic bus_cycle(input int k, input bit w, input logic [7:0] a, input logic [7:0] d,
                           input bit exp_ack, input logic [7:0] exp_rd, input bit ev_at_ack,
                           output logic irq0, output logic irq1);
    int c;
    bit got;
    logic [7:0] e;
    irq0 = 1'b1;
    irq1 = 1'b1;
    @(posedge clk); #1;
    wr = w; pa = a; din = d; iorq_n[k] = 1'b0;
    if (!w && exp_ack) sb_q.push_back(exp_rd);
    got = 0;
    for (c = 1; c <= (exp_ack ? 40 : 20); c++) begin
      @(posedge clk); #1;
      if (!rdy_n[k]) begin got = 1; break; end
      if (ev_at_ack) ev = (c == lat_tab[k] - 1);
    end
    ev = 1'b0;
    if (exp_ack) begin
      check("ack_seen", got, 1);
      if (got) begin
        check("ack_latency", c, lat_tab[k]);
        model_cnt[k] = model_cnt[k] + 8'd1;
        irq0 = irq_n[k];
        if (!w) begin
          e = sb_q.pop_front();
          check("rd_oe", oe[k], 1);
          check("rd_data", dout[k], e);
        end
        @(posedge clk); #1;
        irq1 = irq_n[k];
        check("ack_hold", rdy_n[k], 0);
      end else if (!w) begin
        e = sb_q.pop_front();
      end
    end else begin
      check("miss_no_ack", got, 0);
      check("miss_no_oe", oe[k], 0);
    end
    iorq_n[k] = 1'b1;
    if (got) begin
      for (c = 1; c <= 10; c++) begin
        @(posedge clk); #1;
        if (rdy_n[k]) break;
      end
      check("rel_latency", c, 3);
      check("rel_oe", oe[k], 0);
      check("rel_data", dout[k], 0);
    end
    repeat (3) @(posedge clk);
  endtask

  task automatic pulse_reset();
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    for (int j = 0; j < 3; j++) model_cnt[j] = 8'h00;
    repeat (3) @(posedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic i0, i1;
    bit   seen;

    tbl[0]  = '{0, 1'b1, 8'h40, 8'hA5, 1'b1, 8'h00};
    tbl[1]  = '{0, 1'b0, 8'h40, 8'h00, 1'b1, 8'hA5};
    tbl[2]  = '{0, 1'b1, 8'h41, 8'h3C, 1'b1, 8'h00};
    tbl[3]  = '{0, 1'b0, 8'h41, 8'h00, 1'b1, 8'h3C};
    tbl[4]  = '{0, 1'b0, 8'h42, 8'h00, 1'b1, 8'h00};
    tbl[5]  = '{0, 1'b1, 8'h43, 8'h77, 1'b1, 8'h00};
    tbl[6]  = '{0, 1'b0, 8'h43, 8'h00, 1'b1, 8'h06};
    tbl[7]  = '{0, 1'b0, 8'h50, 8'h00, 1'b0, 8'h00};
    tbl[8]  = '{0, 1'b0, 8'h43, 8'h00, 1'b1, 8'h07};
    tbl[9]  = '{2, 1'b1, 8'h40, 8'h5A, 1'b1, 8'h00};
    tbl[10] = '{2, 1'b0, 8'h40, 8'h00, 1'b1, 8'h5A};
    tbl[11] = '{1, 1'b0, 8'h42, 8'h00, 1'b1, 8'h00};
    tbl[12] = '{0, 1'b0, 8'h40, 8'h00, 1'b1, 8'hA5};
    tbl[13] = '{0, 1'b0, 8'h44, 8'h00, 1'b0, 8'h00};
    tbl[14] = '{0, 1'b0, 8'h43, 8'h00, 1'b1, 8'h09};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_rdy_n", rdy_n, 3'b111);
    check("rst_oe", oe, 3'b000);
    check("rst_irq_n", irq_n, 3'b111);
    check("rst_dout", dout[0], 8'h00);
    check("rst_ctrl", ctrl[0], 8'h00);
    rst = 1'b0;
    repeat (3) @(posedge clk);

    // Table-driven accesses
    for (int i = 0; i < 15; i++)
      bus_cycle(tbl[i].k, tbl[i].w, tbl[i].a, tbl[i].d, tbl[i].ack, tbl[i].rd, 1'b0, i0, i1);
    check("ctrl_out_3c", ctrl[0], 8'h3C);
    check("irq_idle", irq_n[0], 1);

    // Interrupt: enable, then event pulse
    bus_cycle(0, 1'b1, 8'h41, 8'h01, 1'b1, 8'h00, 1'b0, i0, i1);
    check("ctrl_out_01", ctrl[0], 8'h01);
    check("irq_before_ev", irq_n[0], 1);
    @(posedge clk); #1 ev = 1'b1;
    @(posedge clk); #1 ev = 1'b0;
    check("irq_lag", irq_n[0], 1);
    @(posedge clk); #1;
    check("irq_fall", irq_n[0], 0);

    // W1C coinciding with EVENT: set wins
    bus_cycle(0, 1'b1, 8'h42, 8'h01, 1'b1, 8'h00, 1'b1, i0, i1);
    check("w1c_ev_irq0", i0, 0);
    check("w1c_ev_irq1", i1, 0);
    check("w1c_ev_irq_after", irq_n[0], 0);
    bus_cycle(0, 1'b0, 8'h42, 8'h00, 1'b1, 8'h01, 1'b0, i0, i1);

    // W1C alone clears the flag; IRQ releases one cycle after commit
    bus_cycle(0, 1'b1, 8'h42, 8'h01, 1'b1, 8'h00, 1'b0, i0, i1);
    check("w1c_irq_at_commit", i0, 0);
    check("w1c_irq_next", i1, 1);
    bus_cycle(0, 1'b0, 8'h42, 8'h00, 1'b1, 8'h00, 1'b0, i0, i1);

    // Abort during wait states (10 wait states)
    bus_cycle(1, 1'b1, 8'h40, 8'h11, 1'b1, 8'h00, 1'b0, i0, i1);
    @(posedge clk); #1;
    wr = 1'b1; pa = 8'h40; din = 8'h99; iorq_n[1] = 1'b0;
    repeat (6) @(posedge clk);
    #1 iorq_n[1] = 1'b1;
    seen = 0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      if (!rdy_n[1]) seen = 1;
    end
    check("abort_no_ack", seen, 0);
    bus_cycle(1, 1'b0, 8'h40, 8'h00, 1'b1, 8'h11, 1'b0, i0, i1);
    bus_cycle(1, 1'b0, 8'h43, 8'h00, 1'b1, model_cnt[1], 1'b0, i0, i1);

    // Access counter wrap on the zero-wait instance
    pulse_reset();
    for (int i = 0; i < 255; i++)
      bus_cycle(2, 1'b1, 8'h40, 8'(i), 1'b1, 8'h00, 1'b0, i0, i1);
    bus_cycle(2, 1'b0, 8'h43, 8'h00, 1'b1, 8'hFF, 1'b0, i0, i1);
    bus_cycle(2, 1'b0, 8'h43, 8'h00, 1'b1, 8'h00, 1'b0, i0, i1);
    bus_cycle(2, 1'b1, 8'h43, 8'hAA, 1'b1, 8'h00, 1'b0, i0, i1);
    bus_cycle(2, 1'b0, 8'h43, 8'h00, 1'b1, 8'h02, 1'b0, i0, i1);
    bus_cycle(2, 1'b0, 8'h40, 8'h00, 1'b1, 8'hFE, 1'b0, i0, i1);

    // Reset while in ACK with IORQ_n held low
    bus_cycle(0, 1'b1, 8'h40, 8'hC3, 1'b1, 8'h00, 1'b0, i0, i1);
    @(posedge clk); #1;
    wr = 1'b0; pa = 8'h40; iorq_n[0] = 1'b0;
    seen = 0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(posedge clk); #1;
      if (!rdy_n[0]) seen = 1;
    end
    check("pre_rst_ack", seen, 1);
    check("pre_rst_oe", oe[0], 1);
    #2 rst = 1'b1;
    #1;
    check("async_rst_rdy_n", rdy_n[0], 1);
    check("async_rst_oe", oe[0], 0);
    @(posedge clk); #1 rst = 1'b0;
    for (int j = 0; j < 3; j++) model_cnt[j] = 8'h00;
    seen = 0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      if (!rdy_n[0]) seen = 1;
    end
    check("held_low_no_ack", seen, 0);
    iorq_n[0] = 1'b1;
    repeat (3) @(posedge clk);
    bus_cycle(0, 1'b0, 8'h40, 8'h00, 1'b1, 8'h00, 1'b0, i0, i1);

    check("scoreboard_empty", sb_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
